count_stream_checker: RTL and testbench

- Receive-side monitor for the W-bit up/down counter output stream; samples the counter value every enabled cycle.
- Decodes the count direction from consecutive samples, detects wrap-arounds, restarts (return to zero) and illegal jumps.
- Maintains saturating error and direction-change counters for bench self-checking and on-chip debug.
- Sits directly downstream of the counter.

---
 rtl/count_stream_checker.sv | 140 ++++++++++++++
 tb/tb_count_stream_checker.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/count_stream_checker.sv
// Receive-side monitor for an up/down counter stream: classifies each enabled
// sample step and flags wraps, restarts to zero and illegal jumps.
module count_stream_checker #(
  parameter int unsigned W    = 4,
  parameter int unsigned ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sample_en,
  input  logic [W-1:0]    count_in,
  output logic            dir_up,
  output logic            dir_down,
  output logic            hold,
  output logic            wrap_pulse,
  output logic            restart_pulse,
  output logic            err_pulse,
  output logic            locked,
  output logic [ERRW-1:0] err_count,
  output logic [ERRW-1:0] chg_count
);

  typedef enum logic {ACQUIRE, TRACK} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  state_t          state_q, state_d;
  dir_t            last_q, last_d;
  logic [W-1:0]    prev_q, prev_d;
  logic            up_q, up_d, down_q, down_d, hold_q, hold_d;
  logic            wrap_q, wrap_d, restart_q, restart_d, err_q, err_d;
  logic            locked_q, locked_d;
  logic [ERRW-1:0] errc_q, errc_d, chgc_q, chgc_d;

  logic [W-1:0]    delta;
  logic            is_up, is_down, is_hold, is_zero;

  always_comb begin
    delta   = count_in - prev_q;
    is_up   = (delta == W'(1));
    is_down = (delta == '1);
    is_hold = (delta == '0);
    is_zero = (count_in == '0);
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    prev_d    = prev_q;
    up_d      = up_q;
    down_d    = down_q;
    hold_d    = hold_q;
    locked_d  = locked_q;
    errc_d    = errc_q;
    chgc_d    = chgc_q;
    wrap_d    = 1'b0;
    restart_d = 1'b0;
    err_d     = 1'b0;
    if (sample_en) begin
      prev_d = count_in;
      case (state_q)
        ACQUIRE: begin
          state_d  = TRACK;
          locked_d = 1'b1;
        end
        TRACK: begin
          if (is_up) begin
            up_d   = 1'b1;
            down_d = 1'b0;
            hold_d = 1'b0;
            wrap_d = (prev_q == '1);
            if (last_q == DIR_DOWN && chgc_q != '1) chgc_d = chgc_q + ERRW'(1);
            last_d = DIR_UP;
          end else if (is_down) begin
            up_d   = 1'b0;
            down_d = 1'b1;
            hold_d = 1'b0;
            wrap_d = (prev_q == '0);
            if (last_q == DIR_UP && chgc_q != '1) chgc_d = chgc_q + ERRW'(1);
            last_d = DIR_DOWN;
          end else if (is_hold) begin
            // Direction flags and last direction deliberately untouched.
            hold_d = 1'b1;
          end else begin
            up_d   = 1'b0;
            down_d = 1'b0;
            hold_d = 1'b0;
            last_d = DIR_NONE;
            if (is_zero) begin
              restart_d = 1'b1;
            end else begin
              err_d = 1'b1;
              if (errc_q != '1) errc_d = errc_q + ERRW'(1);
            end
          end
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ACQUIRE;
      last_q    <= DIR_NONE;
      prev_q    <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      hold_q    <= 1'b0;
      wrap_q    <= 1'b0;
      restart_q <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      errc_q    <= '0;
      chgc_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      prev_q    <= prev_d;
      up_q      <= up_d;
      down_q    <= down_d;
      hold_q    <= hold_d;
      wrap_q    <= wrap_d;
      restart_q <= restart_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      errc_q    <= errc_d;
      chgc_q    <= chgc_d;
    end
  end

  assign dir_up        = up_q;
  assign dir_down      = down_q;
  assign hold          = hold_q;
  assign wrap_pulse    = wrap_q;
  assign restart_pulse = restart_q;
  assign err_pulse     = err_q;
  assign locked        = locked_q;
  assign err_count     = errc_q;
  assign chg_count     = chgc_q;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker; flags are compared as the vector
// {locked, dir_up, dir_down, hold, wrap, restart, err}.
module tb_count_stream_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en = 1'b0;
  logic [3:0] count_in = '0;
  logic       dir_up, dir_down, hold, wrap_pulse, restart_pulse, err_pulse, locked;
  logic [7:0] err_count, chg_count;

  int checks = 0;
  int errors = 0;

  count_stream_checker #(.W(4), .ERRW(8)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .count_in(count_in),
    .dir_up(dir_up), .dir_down(dir_down), .hold(hold),
    .wrap_pulse(wrap_pulse), .restart_pulse(restart_pulse), .err_pulse(err_pulse),
    .locked(locked), .err_count(err_count), .chg_count(chg_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [6:0] fl, input int ec, input int cc);
    chk({tag, ".flags"}, int'({locked, dir_up, dir_down, hold, wrap_pulse, restart_pulse, err_pulse}), int'(fl));
    chk({tag, ".err_count"}, int'(err_count), ec);
    chk({tag, ".chg_count"}, int'(chg_count), cc);
  endtask

  task automatic step(input logic en, input logic [3:0] v);
    sample_en = en;
    count_in  = v;
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges so the clear must be asynchronous.
  task automatic do_reset(input string tag);
    sample_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_state({tag, ".async"}, 7'b0000000, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #2;
    chk_state("por", 7'b0000000, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_state("por_release", 7'b0000000, 0, 0);

    // Idle in ACQUIRE with sample_en low
    step(1'b0, 4'd9);
    chk_state("acq_idle", 7'b0000000, 0, 0);

    // Up count 0..3
    step(1'b1, 4'd0);  chk_state("t1_ref0", 7'b1000000, 0, 0);
    step(1'b1, 4'd1);  chk_state("t1_up1",  7'b1100000, 0, 0);
    step(1'b1, 4'd2);  chk_state("t1_up2",  7'b1100000, 0, 0);
    step(1'b1, 4'd3);  chk_state("t1_up3",  7'b1100000, 0, 0);

    // Up wrap 13,14,15,0,1 with a disabled cycle after the wrap
    do_reset("t2_rst");
    step(1'b1, 4'd13); chk_state("t2_ref13", 7'b1000000, 0, 0);
    step(1'b1, 4'd14); chk_state("t2_up14",  7'b1100000, 0, 0);
    step(1'b1, 4'd15); chk_state("t2_up15",  7'b1100000, 0, 0);
    step(1'b1, 4'd0);  chk_state("t2_wrap0", 7'b1100100, 0, 0);
    step(1'b0, 4'd7);  chk_state("t2_dis",   7'b1100000, 0, 0);
    step(1'b1, 4'd1);  chk_state("t2_up1",   7'b1100000, 0, 0);

    // Hold, one reversal, down wrap 0->15
    step(1'b1, 4'd2);  chk_state("t3_up2",   7'b1100000, 0, 0);
    step(1'b1, 4'd3);  chk_state("t3_up3",   7'b1100000, 0, 0);
    step(1'b1, 4'd4);  chk_state("t3_up4",   7'b1100000, 0, 0);
    step(1'b1, 4'd4);  chk_state("t3_hold4", 7'b1101000, 0, 0);
    step(1'b1, 4'd3);  chk_state("t3_dn3",   7'b1010000, 0, 1);
    step(1'b1, 4'd2);  chk_state("t3_dn2",   7'b1010000, 0, 1);
    step(1'b1, 4'd1);  chk_state("t3_dn1",   7'b1010000, 0, 1);
    step(1'b1, 4'd0);  chk_state("t3_dn0",   7'b1010000, 0, 1);
    step(1'b1, 4'd15); chk_state("t3_wrap15", 7'b1010100, 0, 1);

    // Illegal jump, then recovery without reversal
    do_reset("t4_rst");
    step(1'b1, 4'd5);  chk_state("t4_ref5", 7'b1000000, 0, 0);
    step(1'b1, 4'd6);  chk_state("t4_up6",  7'b1100000, 0, 0);
    step(1'b1, 4'd9);  chk_state("t4_err9", 7'b1000001, 1, 0);
    step(1'b1, 4'd10); chk_state("t4_up10", 7'b1100000, 1, 0);

    // Jump 10->7 is illegal, 7,8 up, then restart to 0, then illegal 0->6
    step(1'b1, 4'd7);  chk_state("t5_err7",  7'b1000001, 2, 0);
    step(1'b1, 4'd8);  chk_state("t5_up8",   7'b1100000, 2, 0);
    step(1'b1, 4'd0);  chk_state("t5_rst0",  7'b1000010, 2, 0);
    step(1'b1, 4'd6);  chk_state("t5_err6",  7'b1000001, 3, 0);

    // Mid-stream reset: first sample afterwards is reference only
    do_reset("t5_mid");
    chk_state("t5_released", 7'b0000000, 0, 0);
    step(1'b1, 4'd11); chk_state("t5_ref11", 7'b1000000, 0, 0);
    step(1'b1, 4'd12); chk_state("t5_up12",  7'b1100000, 0, 0);

    // 300 illegal jumps: err_count saturates at 255
    for (int i = 0; i < 300; i++) begin
      step(1'b1, (i % 2 == 0) ? 4'h3 : 4'h9);
      if (i == 253) chk_state("t6_err254", 7'b1000001, 254, 0);
      if (i == 254) chk_state("t6_err255", 7'b1000001, 255, 0);
    end
    chk_state("t6_sat", 7'b1000001, 255, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h3);
    chk_state("t6_idle", 7'b1000000, 255, 0);

    // 300 alternating up/down steps: chg_count saturates at 255
    do_reset("t7_rst");
    step(1'b1, 4'd5);
    chk_state("t7_ref5", 7'b1000000, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, (i % 2 == 0) ? 4'd6 : 4'd5);
      if (i == 0)   chk_state("t7_first_up", 7'b1100000, 0, 0);
      if (i == 1)   chk_state("t7_rev1", 7'b1010000, 0, 1);
      if (i == 255) chk_state("t7_rev255", 7'b1010000, 0, 255);
    end
    chk_state("t7_sat", 7'b1010000, 0, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
